// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing the single sprite ROM read port among four pixel fetchers.
// Read data comes back after ROM_LAT cycles, tagged with the requester ID and range-checked.
module sprite_rom_arbiter #(
    parameter int unsigned       ADDR_W      = 14,
    parameter int unsigned       DATA_W      = 24,
    parameter int unsigned       ROM_LAT     = 1,
    parameter int unsigned       DEPTH0      = 1409,
    parameter int unsigned       DEPTH1      = 10600,
    parameter int unsigned       DEPTH2      = 4800,
    parameter int unsigned       DEPTH3      = 5665,
    parameter logic [DATA_W-1:0] TRANSPARENT = 24'hFF00FF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [3:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    output logic [3:0]        ack,
    output logic [1:0]        rom_sel,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        rd_id
);

    localparam int unsigned PID_W = 2 * ROM_LAT;

    logic [1:0]        last_q, last_d;
    logic [3:0]        ack_q, ack_d;
    logic [1:0]        rom_sel_q, rom_sel_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_en_q, rom_en_d;
    logic              forced_q, forced_d;

    logic [ROM_LAT-1:0] pv_q, pv_d;
    logic [ROM_LAT-1:0] pf_q, pf_d;
    logic [PID_W-1:0]   pid_q, pid_d;

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        rd_id_q, rd_id_d;

    logic              grant;
    logic [1:0]        win;
    logic [ADDR_W-1:0] win_addr;
    logic              in_range;

    // Search starts just after the last winner and wraps modulo 4.
    always_comb begin
        logic [1:0] cand;
        grant = 1'b0;
        win   = last_q;
        cand  = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!grant && req[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        win_addr = addr0;
        in_range = 1'b0;
        unique case (win)
            2'd0: begin win_addr = addr0; in_range = 32'(addr0) < DEPTH0; end
            2'd1: begin win_addr = addr1; in_range = 32'(addr1) < DEPTH1; end
            2'd2: begin win_addr = addr2; in_range = 32'(addr2) < DEPTH2; end
            2'd3: begin win_addr = addr3; in_range = 32'(addr3) < DEPTH3; end
        endcase
    end

    always_comb begin
        ack_d      = '0;
        rom_en_d   = 1'b0;
        forced_d   = 1'b0;
        rom_sel_d  = rom_sel_q;
        rom_addr_d = rom_addr_q;
        last_d     = last_q;
        if (grant) begin
            ack_d[win] = 1'b1;
            rom_sel_d  = win;
            rom_addr_d = win_addr;
            rom_en_d   = in_range;
            forced_d   = !in_range;
            last_d     = win;
        end
    end

    // Return pipeline: bit 0 is loaded from the issue cycle, the top stage lines up with rom_data.
    always_comb begin
        pv_d  = (pv_q << 1) | ROM_LAT'(|ack_q);
        pf_d  = (pf_q << 1) | ROM_LAT'(forced_q);
        pid_d = (pid_q << 2) | PID_W'(rom_sel_q);
    end

    assign rd_valid = pv_q[ROM_LAT-1];

    always_comb begin
        rd_data_d = rd_data_q;
        rd_id_d   = rd_id_q;
        if (rd_valid) begin
            rd_id_d   = pid_q[PID_W-1 -: 2];
            rd_data_d = pf_q[ROM_LAT-1] ? TRANSPARENT : rom_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_q     <= 2'd3;
            ack_q      <= '0;
            rom_sel_q  <= '0;
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            forced_q   <= 1'b0;
            pv_q       <= '0;
            pf_q       <= '0;
            pid_q      <= '0;
            rd_data_q  <= '0;
            rd_id_q    <= '0;
        end else begin
            last_q     <= last_d;
            ack_q      <= ack_d;
            rom_sel_q  <= rom_sel_d;
            rom_addr_q <= rom_addr_d;
            rom_en_q   <= rom_en_d;
            forced_q   <= forced_d;
            pv_q       <= pv_d;
            pf_q       <= pf_d;
            pid_q      <= pid_d;
            rd_data_q  <= rd_data_d;
            rd_id_q    <= rd_id_d;
        end
    end

    assign ack      = ack_q;
    assign rom_sel  = rom_sel_q;
    assign rom_addr = rom_addr_q;
    assign rom_en   = rom_en_q;
    assign rd_data  = rd_data_d;
    assign rd_id    = rd_id_d;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM_LAT 1 and 3) against a scoreboard model.
module tb_sprite_rom_arbiter;

    localparam logic [23:0] TRANSP = 24'hFF00FF;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  req;
    logic [13:0] addr0, addr1, addr2, addr3;

    logic [3:0]  ack1, ack3;
    logic [1:0]  rom_sel1, rom_sel3;
    logic [13:0] rom_addr1, rom_addr3;
    logic        rom_en1, rom_en3;
    logic [23:0] rom_data1, rom_data3;
    logic [23:0] rd_data1, rd_data3;
    logic        rd_valid1, rd_valid3;
    logic [1:0]  rd_id1, rd_id3;

    sprite_rom_arbiter #(.ROM_LAT(1)) u_lat1 (
        .Clk(Clk), .Reset_n(Reset_n), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .ack(ack1), .rom_sel(rom_sel1), .rom_addr(rom_addr1), .rom_en(rom_en1),
        .rom_data(rom_data1), .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_id(rd_id1)
    );

    sprite_rom_arbiter #(.ROM_LAT(3)) u_lat3 (
        .Clk(Clk), .Reset_n(Reset_n), .req(req),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .ack(ack3), .rom_sel(rom_sel3), .rom_addr(rom_addr3), .rom_en(rom_en3),
        .rom_data(rom_data3), .rd_data(rd_data3), .rd_valid(rd_valid3), .rd_id(rd_id3)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [23:0] rom_word(input int g, input logic [13:0] a);
        logic [7:0] mix;
        mix = 8'(a) ^ 8'(g * 59) ^ 8'h5C;
        return {2'(g), mix, a};
    endfunction

    function automatic int depth_of(input int g);
        case (g)
            0:       return 1409;
            1:       return 10600;
            2:       return 4800;
            default: return 5665;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // ROM emulation: data appears ROM_LAT cycles after rom_en, junk otherwise.
    logic        p1_en = 1'b0;
    logic [1:0]  p1_sel = '0;
    logic [13:0] p1_addr = '0;
    always @(posedge Clk) begin
        p1_en   <= rom_en1;
        p1_sel  <= rom_sel1;
        p1_addr <= rom_addr1;
    end
    assign rom_data1 = p1_en ? rom_word(int'(p1_sel), p1_addr) : 24'h0BAD01;

    logic [2:0]  p3_en = '0;
    logic [1:0]  p3_sel [3];
    logic [13:0] p3_addr [3];
    always @(posedge Clk) begin
        p3_en      <= {p3_en[1:0], rom_en3};
        p3_sel[0]  <= rom_sel3;
        p3_sel[1]  <= p3_sel[0];
        p3_sel[2]  <= p3_sel[1];
        p3_addr[0] <= rom_addr3;
        p3_addr[1] <= p3_addr[0];
        p3_addr[2] <= p3_addr[1];
    end
    assign rom_data3 = p3_en[2] ? rom_word(int'(p3_sel[2]), p3_addr[2]) : 24'h0BAD03;

    // Reference model state
    typedef struct {
        int          k;
        int          due;
        logic [1:0]  id;
        logic [23:0] data;
    } ret_t;

    ret_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          last_m = 3;
    logic [1:0]  hold_id [2];
    logic [23:0] hold_data [2];
    logic [3:0]  e_ack;
    logic        e_en;
    logic [1:0]  e_sel;
    logic [13:0] e_addr;
    logic        e_chk_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        for (int s = 1; s <= 4; s++)
            if (r[(last + s) % 4]) return (last + s) % 4;
        return -1;
    endfunction

    task automatic check_dut(input int k, input logic [3:0] a_ack, input logic [1:0] a_sel,
                             input logic [13:0] a_addr, input logic a_en, input logic a_v,
                             input logic [1:0] a_id, input logic [23:0] a_data);
        int   idx = -1;
        logic ev = 1'b0;
        string p;
        p = $sformatf("L%0d.", lat_of(k));
        foreach (sb[i])
            if (idx < 0 && sb[i].k == k) idx = i;
        if (idx >= 0 && sb[idx].due == cyc) begin
            ev           = 1'b1;
            hold_id[k]   = sb[idx].id;
            hold_data[k] = sb[idx].data;
            sb.delete(idx);
        end
        chk({p, "ack"}, 32'(a_ack), 32'(e_ack));
        chk({p, "rom_en"}, 32'(a_en), 32'(e_en));
        if (e_chk_sel) begin
            chk({p, "rom_sel"}, 32'(a_sel), 32'(e_sel));
            chk({p, "rom_addr"}, 32'(a_addr), 32'(e_addr));
        end
        chk({p, "rd_valid"}, 32'(a_v), 32'(ev));
        chk({p, "rd_id"}, 32'(a_id), 32'(hold_id[k]));
        chk({p, "rd_data"}, 32'(a_data), 32'(hold_data[k]));
    endtask

    task automatic step(input logic rn, input logic [3:0] r,
                        input logic [13:0] a0, input logic [13:0] a1,
                        input logic [13:0] a2, input logic [13:0] a3);
        logic [13:0] av [4];
        logic [23:0] dat;
        int g;
        av = '{a0, a1, a2, a3};
        Reset_n = rn;
        req = r;
        addr0 = a0; addr1 = a1; addr2 = a2; addr3 = a3;
        e_ack = '0; e_en = 1'b0; e_sel = '0; e_addr = '0; e_chk_sel = 1'b0;
        if (!rn) begin
            sb.delete();
            last_m    = 3;
            hold_id   = '{2'd0, 2'd0};
            hold_data = '{24'd0, 24'd0};
            e_chk_sel = 1'b1;
        end else begin
            g = pick(r, last_m);
            if (g >= 0) begin
                last_m    = g;
                e_ack     = 4'(1 << g);
                e_sel     = 2'(g);
                e_addr    = av[g];
                e_chk_sel = 1'b1;
                e_en      = int'(av[g]) < depth_of(g);
                dat       = e_en ? rom_word(g, av[g]) : TRANSP;
                for (int kk = 0; kk < 2; kk++)
                    sb.push_back('{kk, cyc + 1 + lat_of(kk), 2'(g), dat});
            end
        end
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        check_dut(0, ack1, rom_sel1, rom_addr1, rom_en1, rd_valid1, rd_id1, rd_data1);
        check_dut(1, ack3, rom_sel3, rom_addr3, rom_en3, rd_valid3, rd_id3, rd_data3);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [13:0] a0, a1, a2, a3;
        logic [3:0]  ack;
        logic [1:0]  sel;
        logic [13:0] addr;
        logic        en;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] r, input int a0, input int a1, input int a2,
                       input int a3, input logic [3:0] k, input int s, input int ad,
                       input logic en);
        tbl.push_back('{r, 14'(a0), 14'(a1), 14'(a2), 14'(a3), k, 2'(s), 14'(ad), en});
    endtask

    function automatic logic [13:0] rnd_addr(input int g);
        case ($urandom_range(0, 3))
            0:       return 14'(depth_of(g) - 1);
            1:       return 14'(depth_of(g));
            default: return 14'($urandom_range(0, 16383));
        endcase
    endfunction

    initial begin
        logic [5:0] vh1, vh3;
        logic [1:0] id_a, id_b;
        int         nv;
        logic [1:0] nid;

        hold_id   = '{2'd0, 2'd0};
        hold_data = '{24'd0, 24'd0};
        Reset_n = 1'b0; req = '0;
        addr0 = '0; addr1 = '0; addr2 = '0; addr3 = '0;

        // Arbitration vectors, starting from the reset pointer (last = 3)
        add(4'b0001, 5, 0, 0, 0, 4'b0001, 0, 5, 1'b1);
        add(4'b0000, 5, 0, 0, 0, 4'b0000, 0, 0, 1'b0);
        add(4'b1111, 10, 20, 30, 40, 4'b0010, 1, 20, 1'b1);
        add(4'b1111, 10, 20, 30, 40, 4'b0100, 2, 30, 1'b1);
        add(4'b1111, 10, 20, 30, 40, 4'b1000, 3, 40, 1'b1);
        add(4'b1111, 10, 20, 30, 40, 4'b0001, 0, 10, 1'b1);
        add(4'b1111, 10, 20, 30, 40, 4'b0010, 1, 20, 1'b1);
        add(4'b1111, 10, 20, 30, 40, 4'b0100, 2, 30, 1'b1);
        add(4'b1111, 10, 20, 30, 40, 4'b1000, 3, 40, 1'b1);
        add(4'b1111, 10, 20, 30, 40, 4'b0001, 0, 10, 1'b1);
        add(4'b1111, 10, 20, 30, 40, 4'b0010, 1, 20, 1'b1);
        add(4'b0011, 11, 21, 0, 0, 4'b0001, 0, 11, 1'b1);
        add(4'b0011, 11, 21, 0, 0, 4'b0010, 1, 21, 1'b1);
        add(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 1'b0);
        add(4'b0001, 1409, 0, 0, 0, 4'b0001, 0, 1409, 1'b0);
        add(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 1'b0);
        add(4'b1000, 0, 0, 0, 5664, 4'b1000, 3, 5664, 1'b1);
        add(4'b0100, 0, 0, 4800, 0, 4'b0100, 2, 4800, 1'b0);
        add(4'b0010, 0, 10599, 0, 0, 4'b0010, 1, 10599, 1'b1);
        add(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 1'b0);
        add(4'b0011, 2, 3, 0, 0, 4'b0001, 0, 2, 1'b1);
        add(4'b0000, 2, 3, 0, 0, 4'b0000, 0, 0, 1'b0);
        add(4'b1010, 0, 100, 0, 200, 4'b0010, 1, 100, 1'b1);
        add(4'b1010, 0, 100, 0, 200, 4'b1000, 3, 200, 1'b1);
        add(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 1'b0);

        step(1'b0, 4'b0000, 0, 0, 0, 0);
        step(1'b0, 4'b1111, 0, 0, 0, 0);
        chk("reset.ack", 32'(ack1), 32'd0);
        chk("reset.rom_en", 32'(rom_en1), 32'd0);
        chk("reset.rd_valid", 32'(rd_valid3), 32'd0);
        chk("reset.rd_data", 32'(rd_data1), 32'd0);

        foreach (tbl[i]) begin
            step(1'b1, tbl[i].req, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].a3);
            chk($sformatf("tbl%0d.ack", i), 32'(ack1), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d.en", i), 32'(rom_en1), 32'(tbl[i].en));
            if (tbl[i].ack != 4'b0000) begin
                chk($sformatf("tbl%0d.sel", i), 32'(rom_sel1), 32'(tbl[i].sel));
                chk($sformatf("tbl%0d.addr", i), 32'(rom_addr1), 32'(tbl[i].addr));
            end
        end

        // Grants in consecutive cycles return in order, exactly ROM_LAT later
        step(1'b0, 4'b0000, 0, 0, 0, 0);
        vh1 = '0; vh3 = '0; id_a = '0; id_b = '0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      step(1'b1, 4'b0001, 7, 0, 0, 0);
            else if (i == 1) step(1'b1, 4'b0010, 7, 9, 0, 0);
            else             step(1'b1, 4'b0000, 7, 9, 0, 0);
            vh1[i] = rd_valid1;
            vh3[i] = rd_valid3;
            if (i == 3) id_a = rd_id3;
            if (i == 4) id_b = rd_id3;
        end
        chk("lat1.valid_seq", 32'(vh1), 32'(6'b000110));
        chk("lat3.valid_seq", 32'(vh3), 32'(6'b011000));
        chk("lat3.first_id", 32'(id_a), 32'd0);
        chk("lat3.second_id", 32'(id_b), 32'd1);
        chk("lat3.held_data", 32'(rd_data3), 32'(rom_word(1, 14'd9)));

        // Reset right after a grant drops that read
        step(1'b1, 4'b0100, 0, 0, 3, 0);
        step(1'b0, 4'b0000, 0, 0, 3, 0);
        chk("midrst.rd_valid", 32'(rd_valid1), 32'd0);
        nv = 0; nid = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i == 0) ? 4'b1110 : 4'b0000, 0, 5, 6, 7);
            if (i == 0) chk("midrst.ack", 32'(ack1), 32'(4'b0010));
            if (rd_valid3) begin
                nv++;
                nid = rd_id3;
            end
        end
        chk("midrst.lat3_returns", 32'(nv), 32'd1);
        chk("midrst.lat3_id", 32'(nid), 32'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), 4'($urandom),
                 rnd_addr(0), rnd_addr(1), rnd_addr(2), rnd_addr(3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
